sync2async_pulse: RTL



---
 rtl/sync2async_pkg.sv | 21 ++
 rtl/sync2_ff.sv | 23 ++
 rtl/sync2async_pulse.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sync2async_pkg.sv
// Shared types and helpers for the sync2async_pulse transmitter.
// The FSM state encoding and counter-width calculation are shared by the RTL files.
package sync2async_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HIGH     = 2'd1,
        WAIT_ACK = 2'd2,
        LOW_GAP  = 2'd3
    } s2a_state_t;

    // The counter must hold the longest phase length it ever reloads with.
    function automatic int cnt_width(input int stretch, input int gap, input int timeout);
        int m;
        m = stretch;
        if (gap > m) m = gap;
        if (timeout > m) m = timeout;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync2_ff.sv
// Generic two-flop level synchronizer with synchronous active-high reset.
module sync2_ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sync2async_pulse.sv
// Stretched-pulse transmitter toward a slower or asynchronous receiver.
// Define SYNC2ASYNC_ACK_HANDSHAKE_EN to add the four-phase ack handshake with timeout.
module sync2async_pulse
    import sync2async_pkg::*;
#(
    parameter int STRETCH = 4,
    parameter int GAP     = 2,
    parameter int DROP_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulse_in,
    input  logic              ack_in,
    output logic              async_out,
    output logic              busy,
    output logic [DROP_W-1:0] drop_count,
    output logic              ack_timeout
);

    localparam int CNT_W = cnt_width(STRETCH, GAP, TIMEOUT);
    localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(GAP - 1);

    s2a_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              pending, pending_nxt;
    logic [DROP_W-1:0] drop_nxt;
    logic              cnt_done;
    logic              ack_low;
    logic              consume;
    logic              direct;

`ifdef SYNC2ASYNC_ACK_HANDSHAKE_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT - 1);
    logic ack_s;
    logic timeout_set;

    sync2_ff #(.RESET_VAL(1'b0)) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ack_in),
        .q     (ack_s)
    );

    assign ack_low = ~ack_s;

    always_ff @(posedge clk) begin
        if (reset)
            ack_timeout <= 1'b0;
        else if (timeout_set)
            ack_timeout <= 1'b1;
    end
`else
    logic unused_ack;

    assign unused_ack  = ack_in;
    assign ack_low     = 1'b1;
    assign ack_timeout = 1'b0;
`endif

    assign cnt_done = (cnt == '0);
    // Derived from registers only, so pulse_in never reaches busy combinationally.
    assign busy = (state != IDLE) || pending;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pending_nxt = pending;
        drop_nxt    = drop_count;
        consume     = 1'b0;
        direct      = 1'b0;
`ifdef SYNC2ASYNC_ACK_HANDSHAKE_EN
        timeout_set = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pulse_in) begin
                    state_nxt = HIGH;
                    cnt_nxt   = STRETCH_LD;
                end
            end
            HIGH: begin
                if (cnt_done) begin
`ifdef SYNC2ASYNC_ACK_HANDSHAKE_EN
                    state_nxt = WAIT_ACK;
                    cnt_nxt   = TIMEOUT_LD;
`else
                    state_nxt = LOW_GAP;
                    cnt_nxt   = GAP_LD;
`endif
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
`ifdef SYNC2ASYNC_ACK_HANDSHAKE_EN
            WAIT_ACK: begin
                if (ack_s) begin
                    state_nxt = LOW_GAP;
                    cnt_nxt   = GAP_LD;
                end else if (cnt_done) begin
                    state_nxt   = LOW_GAP;
                    cnt_nxt     = GAP_LD;
                    timeout_set = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
`endif
            LOW_GAP: begin
                // Counter parks at zero while waiting for the ack to fall.
                if (cnt_done && ack_low) begin
                    if (pending) begin
                        state_nxt = HIGH;
                        cnt_nxt   = STRETCH_LD;
                        consume   = 1'b1;
                    end else if (pulse_in) begin
                        state_nxt = HIGH;
                        cnt_nxt   = STRETCH_LD;
                        direct    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end else if (!cnt_done) begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // An event on the edge that consumes pending refills the one-deep buffer.
        if ((state != IDLE) && pulse_in && !direct) begin
            if (consume || !pending)
                pending_nxt = 1'b1;
            else if (drop_count != '1)
                drop_nxt = drop_count + 1'b1;
        end else if (consume) begin
            pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            pending    <= 1'b0;
            drop_count <= '0;
            async_out  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pending    <= pending_nxt;
            drop_count <= drop_nxt;
            async_out  <= (state_nxt == HIGH) || (state_nxt == WAIT_ACK);
        end
    end

endmodule
